// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RISC-V opcode constants, type codes and decode structs
//
// Purpose : opcode constants, instruction-format codes, output buffer occupancy
//           states and the decoded-field record carried through the buffer.
// Ports   : none (package).
package riscv_pkg;

  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_SYSTEM = 7'h73;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6f;

  typedef enum logic [2:0] {
    TYPE_R   = 3'd0,
    TYPE_I   = 3'd1,
    TYPE_S   = 3'd2,
    TYPE_B   = 3'd3,
    TYPE_U   = 3'd4,
    TYPE_J   = 3'd5,
    TYPE_ILL = 3'd7
  } inst_type_e;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_state_e;

  typedef struct packed {
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [2:0] funct3;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [6:0] funct7;
    inst_type_e itype;
    logic       illegal;
  } inst_fields_t;

endpackage

// File: rtl/inst_field_decode.sv
// rtl/inst_field_decode.sv - combinational field, format, immediate and legality decode
//
// Purpose : splits a raw instruction into its fields, classifies the format and
//           builds the sign-extended immediate.
// Ports   : inst   in  raw instruction (fields from bits 31:0)
//           fields out raw fields, format code, illegal flag
//           imm    out sign-extended immediate (0 for R and illegal)
module inst_field_decode
  import riscv_pkg::*;
#(
  parameter int W_SIZE = 32,
  parameter int CSR_EN = 1
) (
  input  logic [W_SIZE-1:0] inst,
  output inst_fields_t      fields,
  output logic [W_SIZE-1:0] imm
);

  inst_type_e itype;

  always_comb begin
    itype = TYPE_ILL;
    // Compressed encodings (low bits != 11) are never legal here.
    if (inst[1:0] == 2'b11) begin
      case (inst[6:0])
        OPC_OP:                          itype = TYPE_R;
        OPC_OP_IMM, OPC_LOAD, OPC_JALR:  itype = TYPE_I;
        OPC_SYSTEM:                      itype = (CSR_EN != 0) ? TYPE_I : TYPE_ILL;
        OPC_STORE:                       itype = TYPE_S;
        OPC_BRANCH:                      itype = TYPE_B;
        OPC_LUI, OPC_AUIPC:              itype = TYPE_U;
        OPC_JAL:                         itype = TYPE_J;
        default:                         itype = TYPE_ILL;
      endcase
    end
  end

  always_comb begin
    imm = '0;
    case (itype)
      TYPE_I: imm = W_SIZE'($signed(inst[31:20]));
      TYPE_S: imm = W_SIZE'($signed({inst[31:25], inst[11:7]}));
      TYPE_B: imm = W_SIZE'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
      TYPE_U: imm = W_SIZE'($signed({inst[31:12], 12'b0}));
      TYPE_J: imm = W_SIZE'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
      default: imm = '0;
    endcase
  end

  always_comb begin
    fields.opcode  = inst[6:0];
    fields.rd      = inst[11:7];
    fields.funct3  = inst[14:12];
    fields.rs1     = inst[19:15];
    fields.rs2     = inst[24:20];
    fields.funct7  = inst[31:25];
    fields.itype   = itype;
    fields.illegal = (itype == TYPE_ILL);
  end

endmodule

// File: rtl/inst_decode_stage.sv
// rtl/inst_decode_stage.sv - registered instruction decode stage with 1/2-entry output buffer
//
// Purpose : decodes each accepted instruction and holds it in a small FIFO
//           buffer presented to the downstream stage with valid/ready.
// Ports   : clk, rst_n              clock, async active-low reset
//           in_valid/in_ready       upstream handshake, in_inst/in_pc payload
//           flush                   drop buffered and same-cycle instructions
//           out_valid/out_ready     downstream handshake
//           out_opcode..out_funct7  raw fields of head entry
//           out_type, out_imm       format code and sign-extended immediate
//           out_pc, out_illegal     PC and illegal flag of head entry
module inst_decode_stage
  import riscv_pkg::*;
#(
  parameter int W_SIZE = 32,
  parameter int DEPTH  = 2,
  parameter int CSR_EN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W_SIZE-1:0] in_inst,
  input  logic [W_SIZE-1:0] in_pc,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [6:0]        out_opcode,
  output logic [4:0]        out_rd,
  output logic [2:0]        out_funct3,
  output logic [4:0]        out_rs1,
  output logic [4:0]        out_rs2,
  output logic [6:0]        out_funct7,
  output logic [2:0]        out_type,
  output logic [W_SIZE-1:0] out_imm,
  output logic [W_SIZE-1:0] out_pc,
  output logic              out_illegal
);

  occ_state_e        state_q, state_d;
  inst_fields_t      head_q, head_d, tail_q, tail_d, dec_fields;
  logic [W_SIZE-1:0] head_imm_q, head_imm_d, tail_imm_q, tail_imm_d, dec_imm;
  logic [W_SIZE-1:0] head_pc_q, head_pc_d, tail_pc_q, tail_pc_d;
  // Keeps in_ready low until the first clock edge after reset release.
  logic              rdy_en_q;
  logic              push, pop;

  inst_field_decode #(.W_SIZE(W_SIZE), .CSR_EN(CSR_EN)) u_decode (
    .inst   (in_inst),
    .fields (dec_fields),
    .imm    (dec_imm)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= OCC_EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    head_d     = head_q;
    head_imm_d = head_imm_q;
    head_pc_d  = head_pc_q;
    tail_d     = tail_q;
    tail_imm_d = tail_imm_q;
    tail_pc_d  = tail_pc_q;
    in_ready   = 1'b0;
    out_valid  = (state_q != OCC_EMPTY);

    if (rdy_en_q && !flush) begin
      case (state_q)
        OCC_EMPTY: in_ready = 1'b1;
        // Single-entry buffer can only refill when the head leaves this cycle.
        OCC_ONE:   in_ready = (DEPTH == 2) ? 1'b1 : out_ready;
        default:   in_ready = 1'b0;
      endcase
    end

    push = in_valid && in_ready;
    pop  = out_valid && out_ready;

    if (flush) begin
      state_d = OCC_EMPTY;
    end else begin
      case (state_q)
        OCC_EMPTY: begin
          if (push) begin
            head_d = dec_fields; head_imm_d = dec_imm; head_pc_d = in_pc;
            state_d = OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (push && pop) begin
            head_d = dec_fields; head_imm_d = dec_imm; head_pc_d = in_pc;
          end else if (push && (DEPTH == 2)) begin
            tail_d = dec_fields; tail_imm_d = dec_imm; tail_pc_d = in_pc;
            state_d = OCC_TWO;
          end else if (pop) begin
            state_d = OCC_EMPTY;
          end
        end
        OCC_TWO: begin
          if (pop) begin
            head_d = tail_q; head_imm_d = tail_imm_q; head_pc_d = tail_pc_q;
            state_d = OCC_ONE;
          end
        end
        default: state_d = OCC_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en_q   <= 1'b0;
      head_q     <= '0;
      head_imm_q <= '0;
      head_pc_q  <= '0;
      tail_q     <= '0;
      tail_imm_q <= '0;
      tail_pc_q  <= '0;
    end else begin
      rdy_en_q   <= 1'b1;
      head_q     <= head_d;
      head_imm_q <= head_imm_d;
      head_pc_q  <= head_pc_d;
      tail_q     <= tail_d;
      tail_imm_q <= tail_imm_d;
      tail_pc_q  <= tail_pc_d;
    end
  end

  assign out_opcode  = head_q.opcode;
  assign out_rd      = head_q.rd;
  assign out_funct3  = head_q.funct3;
  assign out_rs1     = head_q.rs1;
  assign out_rs2     = head_q.rs2;
  assign out_funct7  = head_q.funct7;
  assign out_type    = head_q.itype;
  assign out_illegal = head_q.illegal;
  assign out_imm     = head_imm_q;
  assign out_pc      = head_pc_q;

endmodule

// File: tb/tb_inst_decode_stage.sv
// tb/tb_inst_decode_stage.sv - directed self-checking bench for inst_decode_stage
module tb_inst_decode_stage;

  logic        clk, rst_n, in_valid, flush, out_ready;
  logic [31:0] in_inst, in_pc;

  logic        a_in_ready, a_out_valid, a_out_illegal;
  logic [6:0]  a_out_opcode, a_out_funct7;
  logic [4:0]  a_out_rd, a_out_rs1, a_out_rs2;
  logic [2:0]  a_out_funct3, a_out_type;
  logic [31:0] a_out_imm, a_out_pc;

  logic        n_in_ready, n_out_valid, n_out_illegal;
  logic [6:0]  n_out_opcode, n_out_funct7;
  logic [4:0]  n_out_rd, n_out_rs1, n_out_rs2;
  logic [2:0]  n_out_funct3, n_out_type;
  logic [31:0] n_out_imm, n_out_pc;

  logic        s_in_ready, s_out_valid, s_out_illegal;
  logic [6:0]  s_out_opcode, s_out_funct7;
  logic [4:0]  s_out_rd, s_out_rs1, s_out_rs2;
  logic [2:0]  s_out_funct3, s_out_type;
  logic [31:0] s_out_imm, s_out_pc;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [31:0] tv_inst [8];
  logic [2:0]  tv_type [8];
  logic [31:0] tv_imm  [8];
  logic        tv_ill  [8];

  inst_decode_stage #(.W_SIZE(32), .DEPTH(2), .CSR_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .flush(flush),
    .out_valid(a_out_valid), .out_ready(out_ready),
    .out_opcode(a_out_opcode), .out_rd(a_out_rd), .out_funct3(a_out_funct3),
    .out_rs1(a_out_rs1), .out_rs2(a_out_rs2), .out_funct7(a_out_funct7),
    .out_type(a_out_type), .out_imm(a_out_imm), .out_pc(a_out_pc),
    .out_illegal(a_out_illegal)
  );

  inst_decode_stage #(.W_SIZE(32), .DEPTH(2), .CSR_EN(0)) dut_nocsr (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(n_in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .flush(flush),
    .out_valid(n_out_valid), .out_ready(out_ready),
    .out_opcode(n_out_opcode), .out_rd(n_out_rd), .out_funct3(n_out_funct3),
    .out_rs1(n_out_rs1), .out_rs2(n_out_rs2), .out_funct7(n_out_funct7),
    .out_type(n_out_type), .out_imm(n_out_imm), .out_pc(n_out_pc),
    .out_illegal(n_out_illegal)
  );

  inst_decode_stage #(.W_SIZE(32), .DEPTH(1), .CSR_EN(1)) dut_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .flush(flush),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .out_opcode(s_out_opcode), .out_rd(s_out_rd), .out_funct3(s_out_funct3),
    .out_rs1(s_out_rs1), .out_rs2(s_out_rs2), .out_funct7(s_out_funct7),
    .out_type(s_out_type), .out_imm(s_out_imm), .out_pc(s_out_pc),
    .out_illegal(s_out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic push1(input logic [31:0] inst, input logic [31:0] pc);
    @(negedge clk);
    in_valid = 1'b1; in_inst = inst; in_pc = pc;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic pop1();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_inst = '0; in_pc = '0;
    repeat (2) @(negedge clk);
    total_cnt++; if (a_out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", a_out_valid); else pass_cnt++;
    total_cnt++; if (a_in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b want 0", a_in_ready); else pass_cnt++;
    total_cnt++; if (a_out_imm !== 32'h0) $display("FAIL rst_out_imm: got %h want 0", a_out_imm); else pass_cnt++;
    total_cnt++; if (a_out_pc !== 32'h0) $display("FAIL rst_out_pc: got %h want 0", a_out_pc); else pass_cnt++;
    total_cnt++; if (a_out_type !== 3'd0) $display("FAIL rst_out_type: got %0d want 0", a_out_type); else pass_cnt++;
    rst_n = 1'b1;
    #1;
    total_cnt++; if (a_in_ready !== 1'b0) $display("FAIL rst_release_ready_early: got %b want 0", a_in_ready); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (a_in_ready !== 1'b1) $display("FAIL rst_release_ready: got %b want 1", a_in_ready); else pass_cnt++;
  endtask

  task automatic test_addi();
    do_reset();
    @(negedge clk);
    in_valid = 1'b1; in_inst = 32'hFFF00093; in_pc = 32'h100;
    #1;
    total_cnt++; if (a_out_valid !== 1'b0) $display("FAIL addi_no_comb_path: got %b want 0", a_out_valid); else pass_cnt++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    total_cnt++; if (a_out_valid !== 1'b1) $display("FAIL addi_valid: got %b want 1", a_out_valid); else pass_cnt++;
    total_cnt++; if (a_out_type !== 3'd1) $display("FAIL addi_type: got %0d want 1", a_out_type); else pass_cnt++;
    total_cnt++; if (a_out_imm !== 32'hFFFFFFFF) $display("FAIL addi_imm: got %h want ffffffff", a_out_imm); else pass_cnt++;
    total_cnt++; if (a_out_rd !== 5'd1) $display("FAIL addi_rd: got %0d want 1", a_out_rd); else pass_cnt++;
    total_cnt++; if (a_out_opcode !== 7'h13) $display("FAIL addi_opcode: got %h want 13", a_out_opcode); else pass_cnt++;
    total_cnt++; if (a_out_pc !== 32'h100) $display("FAIL addi_pc: got %h want 100", a_out_pc); else pass_cnt++;
    total_cnt++; if (a_out_illegal !== 1'b0) $display("FAIL addi_illegal: got %b want 0", a_out_illegal); else pass_cnt++;
    pop1();
    total_cnt++; if (a_out_valid !== 1'b0) $display("FAIL addi_pop_empty: got %b want 0", a_out_valid); else pass_cnt++;
  endtask

  task automatic test_types();
    tv_inst = '{32'hFE000EE3, 32'hFE20AC23, 32'h800002B7, 32'h001000EF,
                32'h402081B3, 32'hFFFFF017, 32'h002081B2, 32'h00002073};
    tv_type = '{3'd3, 3'd2, 3'd4, 3'd5, 3'd0, 3'd4, 3'd7, 3'd1};
    tv_imm  = '{32'hFFFFFFFC, 32'hFFFFFFF8, 32'h80000000, 32'h00000800,
                32'h0, 32'hFFFFF000, 32'h0, 32'h0};
    tv_ill  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      push1(tv_inst[i], 32'h200 + 32'(i * 4));
      total_cnt++; if (a_out_type !== tv_type[i]) $display("FAIL types_type[%0d]: got %0d want %0d", i, a_out_type, tv_type[i]); else pass_cnt++;
      total_cnt++; if (a_out_imm !== tv_imm[i]) $display("FAIL types_imm[%0d]: got %h want %h", i, a_out_imm, tv_imm[i]); else pass_cnt++;
      total_cnt++; if (a_out_illegal !== tv_ill[i]) $display("FAIL types_illegal[%0d]: got %b want %b", i, a_out_illegal, tv_ill[i]); else pass_cnt++;
      total_cnt++; if (a_out_pc !== 32'h200 + 32'(i * 4)) $display("FAIL types_pc[%0d]: got %h want %h", i, a_out_pc, 32'h200 + 32'(i * 4)); else pass_cnt++;
      pop1();
    end
  endtask

  task automatic test_csr_disabled();
    do_reset();
    push1(32'h00002073, 32'h300);
    total_cnt++; if (n_out_type !== 3'd7) $display("FAIL nocsr_type: got %0d want 7", n_out_type); else pass_cnt++;
    total_cnt++; if (n_out_illegal !== 1'b1) $display("FAIL nocsr_illegal: got %b want 1", n_out_illegal); else pass_cnt++;
    total_cnt++; if (n_out_imm !== 32'h0) $display("FAIL nocsr_imm: got %h want 0", n_out_imm); else pass_cnt++;
    total_cnt++; if (a_out_type !== 3'd1) $display("FAIL csr_en_type: got %0d want 1", a_out_type); else pass_cnt++;
    pop1();
    push1(32'h00000000, 32'h304);
    total_cnt++; if (n_out_type !== 3'd7) $display("FAIL zero_type_nocsr: got %0d want 7", n_out_type); else pass_cnt++;
    total_cnt++; if (n_out_illegal !== 1'b1) $display("FAIL zero_illegal_nocsr: got %b want 1", n_out_illegal); else pass_cnt++;
    total_cnt++; if (a_out_illegal !== 1'b1) $display("FAIL zero_illegal: got %b want 1", a_out_illegal); else pass_cnt++;
    pop1();
  endtask

  task automatic test_back_to_back();
    do_reset();
    @(negedge clk);
    in_valid = 1'b1; in_inst = 32'hFFF00093; in_pc = 32'h10;
    #1;
    total_cnt++; if (a_in_ready !== 1'b1) $display("FAIL b2b_ready_1: got %b want 1", a_in_ready); else pass_cnt++;
    @(posedge clk); #1;
    in_inst = 32'h402081B3; in_pc = 32'h14;
    total_cnt++; if (a_in_ready !== 1'b1) $display("FAIL b2b_ready_2: got %b want 1", a_in_ready); else pass_cnt++;
    total_cnt++; if (a_out_pc !== 32'h10) $display("FAIL b2b_head_1: got %h want 10", a_out_pc); else pass_cnt++;
    @(posedge clk); #1;
    in_inst = 32'h800002B7; in_pc = 32'h18;
    total_cnt++; if (a_in_ready !== 1'b0) $display("FAIL b2b_full_ready: got %b want 0", a_in_ready); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (a_out_pc !== 32'h10) $display("FAIL b2b_hold_pc: got %h want 10", a_out_pc); else pass_cnt++;
    total_cnt++; if (a_out_imm !== 32'hFFFFFFFF) $display("FAIL b2b_hold_imm: got %h want ffffffff", a_out_imm); else pass_cnt++;
    total_cnt++; if (a_in_ready !== 1'b0) $display("FAIL b2b_hold_ready: got %b want 0", a_in_ready); else pass_cnt++;
    out_ready = 1'b1;
    @(posedge clk); #1;
    total_cnt++; if (a_out_pc !== 32'h14) $display("FAIL b2b_second_pc: got %h want 14", a_out_pc); else pass_cnt++;
    total_cnt++; if (a_out_funct7 !== 7'h20) $display("FAIL b2b_second_funct7: got %h want 20", a_out_funct7); else pass_cnt++;
    total_cnt++; if (a_out_rs2 !== 5'd2 || a_out_rs1 !== 5'd1 || a_out_rd !== 5'd3) $display("FAIL b2b_second_regs: got %0d/%0d/%0d want 2/1/3", a_out_rs2, a_out_rs1, a_out_rd); else pass_cnt++;
    total_cnt++; if (a_in_ready !== 1'b1) $display("FAIL b2b_ready_after_pop: got %b want 1", a_in_ready); else pass_cnt++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    total_cnt++; if (a_out_pc !== 32'h18) $display("FAIL b2b_third_pc: got %h want 18", a_out_pc); else pass_cnt++;
    total_cnt++; if (a_out_type !== 3'd4) $display("FAIL b2b_third_type: got %0d want 4", a_out_type); else pass_cnt++;
    @(posedge clk); #1;
    out_ready = 1'b0;
    total_cnt++; if (a_out_valid !== 1'b0) $display("FAIL b2b_drained: got %b want 0", a_out_valid); else pass_cnt++;
  endtask

  task automatic test_flush();
    do_reset();
    push1(32'hFFF00093, 32'h20);
    push1(32'h402081B3, 32'h24);
    total_cnt++; if (a_in_ready !== 1'b0) $display("FAIL flush_full: got %b want 0", a_in_ready); else pass_cnt++;
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; in_inst = 32'h800002B7; in_pc = 32'h28; out_ready = 1'b1;
    #1;
    total_cnt++; if (a_in_ready !== 1'b0) $display("FAIL flush_cycle_ready: got %b want 0", a_in_ready); else pass_cnt++;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    total_cnt++; if (a_out_valid !== 1'b0) $display("FAIL flush_empty: got %b want 0", a_out_valid); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (a_out_valid !== 1'b0) $display("FAIL flush_no_ghost: got %b want 0", a_out_valid); else pass_cnt++;
    total_cnt++; if (a_in_ready !== 1'b1) $display("FAIL flush_ready_back: got %b want 1", a_in_ready); else pass_cnt++;
    out_ready = 1'b0;
    push1(32'h001000EF, 32'h2C);
    total_cnt++; if (a_out_pc !== 32'h2C) $display("FAIL flush_next_pc: got %h want 2c", a_out_pc); else pass_cnt++;
    pop1();
  endtask

  task automatic test_reset_mid();
    do_reset();
    push1(32'hFFF00093, 32'h30);
    total_cnt++; if (a_out_valid !== 1'b1) $display("FAIL rmid_pre_valid: got %b want 1", a_out_valid); else pass_cnt++;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    total_cnt++; if (a_out_valid !== 1'b0) $display("FAIL rmid_async_valid: got %b want 0", a_out_valid); else pass_cnt++;
    total_cnt++; if (a_out_pc !== 32'h0) $display("FAIL rmid_async_pc: got %h want 0", a_out_pc); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total_cnt++; if (a_in_ready !== 1'b0) $display("FAIL rmid_ready_early: got %b want 0", a_in_ready); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) $display("FAIL rmid_resume: got ready=%b valid=%b want 1/0", a_in_ready, a_out_valid); else pass_cnt++;
    push1(32'h800002B7, 32'h34);
    total_cnt++; if (a_out_pc !== 32'h34) $display("FAIL rmid_new_pc: got %h want 34", a_out_pc); else pass_cnt++;
    pop1();
  endtask

  task automatic test_depth1();
    do_reset();
    push1(32'hFFF00093, 32'h50);
    total_cnt++; if (s_out_valid !== 1'b1) $display("FAIL d1_valid: got %b want 1", s_out_valid); else pass_cnt++;
    total_cnt++; if (s_in_ready !== 1'b0) $display("FAIL d1_ready_blocked: got %b want 0", s_in_ready); else pass_cnt++;
    @(negedge clk);
    in_valid = 1'b1; in_inst = 32'h001000EF; in_pc = 32'h54; out_ready = 1'b1;
    #1;
    total_cnt++; if (s_in_ready !== 1'b1) $display("FAIL d1_passthrough_ready: got %b want 1", s_in_ready); else pass_cnt++;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    total_cnt++; if (s_out_pc !== 32'h54 || s_out_valid !== 1'b1) $display("FAIL d1_refill: got pc=%h valid=%b want 54/1", s_out_pc, s_out_valid); else pass_cnt++;
    total_cnt++; if (s_out_type !== 3'd5) $display("FAIL d1_type: got %0d want 5", s_out_type); else pass_cnt++;
    pop1();
    total_cnt++; if (s_out_valid !== 1'b0) $display("FAIL d1_drained: got %b want 0", s_out_valid); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_addi();
    test_types();
    test_csr_disabled();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_depth1();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
